// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO around a dual_port_ram: sequences RAM addresses, hides the
// RAM read latency behind a small output buffer and exposes valid/ready on both sides.

module dual_port_ram #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 5,
    parameter int REGISTERED_OUTPUT = 0
) (
    input  logic                  wr_clk_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_clk_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage array write port
    always_ff @(posedge wr_clk_i) begin
        if (wr_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Synchronous read port, updated only on a read request
    always_ff @(posedge rd_clk_i) begin
        if (rd_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    if (REGISTERED_OUTPUT != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        // Extra output stage; sampled every cycle, validity is tracked by the controller
        always_ff @(posedge rd_clk_i) begin
            out_q <= rd_q;
        end
        assign rd_data_o = out_q;
    end else begin : g_out_direct
        assign rd_data_o = rd_q;
    end
endmodule

module ram_fifo_ctrl #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 5,
    parameter int REGISTERED_OUTPUT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int LAT       = 1 + REGISTERED_OUTPUT;
    localparam int OUT_DEPTH = LAT + 1;
    localparam int BP_W      = $clog2(OUT_DEPTH);
    localparam int BC_W      = $clog2(OUT_DEPTH + 1);

    localparam logic [ADDR_WIDTH:0]   CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_INC  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_INC  = (ADDR_WIDTH + 1)'(1);
    localparam logic [BC_W-1:0]       BC_INC   = BC_W'(1);
    localparam logic [BP_W-1:0]       BP_INC   = BP_W'(1);
    localparam logic [BP_W-1:0]       BP_LAST  = BP_W'(OUT_DEPTH - 1);
    localparam logic [BP_W-1:0]       BP_ZERO  = BP_W'(0);
    localparam logic [BC_W:0]         OUT_ROOM = (BC_W + 1)'(OUT_DEPTH);

    function automatic logic [BC_W-1:0] count_ones(input logic [LAT-1:0] v);
        logic [BC_W-1:0] c;
        c = BC_W'(0);
        for (int i = 0; i < LAT; i++) begin
            c = c + BC_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [BP_W-1:0] buf_next(input logic [BP_W-1:0] idx);
        return (idx == BP_LAST) ? BP_ZERO : idx + BP_INC;
    endfunction

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic [ADDR_WIDTH:0]   used_q, used_d;
    logic [LAT-1:0]        trk_q, trk_d;
    logic [BP_W-1:0]       head_q, head_d;
    logic [BP_W-1:0]       tail_q, tail_d;
    logic [BC_W-1:0]       buf_count_q, buf_count_d;
    logic [DATA_WIDTH-1:0] buf_mem_q [OUT_DEPTH];

    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic                  land_s;
    logic [BC_W:0]         occupancy_s;
    logic [BC_W:0]         room_s;
    logic [DATA_WIDTH-1:0] ram_rd_data_s;

    assign wr_ready_o   = !rst_i && (used_q < CAPACITY);
    assign push_s       = wr_valid_i && wr_ready_o;
    assign rd_valid_o   = |buf_count_q;
    assign pop_s        = rd_valid_o && rd_ready_i;
    assign rd_data_o    = buf_mem_q[head_q];
    assign used_words_o = used_q;
    assign full_o       = (used_q == CAPACITY);
    assign empty_o      = ~|used_q;
    assign land_s       = trk_q[LAT-1];

    // A read may issue only if the buffer can absorb it once all in-flight reads land
    assign occupancy_s = {1'b0, buf_count_q} + {1'b0, count_ones(trk_q)};
    assign room_s      = OUT_ROOM + {{BC_W{1'b0}}, pop_s};
    assign issue_s     = !rst_i && (|ram_count_q) && (occupancy_s < room_s);

    dual_port_ram #(
        .DATA_WIDTH        (DATA_WIDTH),
        .ADDR_WIDTH        (ADDR_WIDTH),
        .REGISTERED_OUTPUT (REGISTERED_OUTPUT)
    ) u_ram (
        .wr_clk_i  (clk_i),
        .wr_i      (push_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_clk_i  (clk_i),
        .rd_i      (issue_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data_s)
    );

    // Next-state for pointers, counters, read tracker and output buffer indices
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        used_d      = used_q;
        trk_d       = trk_q;
        head_d      = head_q;
        tail_d      = tail_q;
        buf_count_d = buf_count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_INC;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (issue_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, issue_s})
            2'b10:   ram_count_d = ram_count_q + CNT_INC;
            2'b01:   ram_count_d = ram_count_q - CNT_INC;
            default: ram_count_d = ram_count_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   used_d = used_q + CNT_INC;
            2'b01:   used_d = used_q - CNT_INC;
            default: used_d = used_q;
        endcase

        trk_d[0] = issue_s;
        for (int i = 1; i < LAT; i++) begin
            trk_d[i] = trk_q[i-1];
        end

        if (land_s) begin
            tail_d = buf_next(tail_q);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = buf_next(head_q);
        end else begin
            head_d = head_q;
        end

        case ({land_s, pop_s})
            2'b10:   buf_count_d = buf_count_q + BC_INC;
            2'b01:   buf_count_d = buf_count_q - BC_INC;
            default: buf_count_d = buf_count_q;
        endcase
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
            ram_count_q <= {(ADDR_WIDTH + 1){1'b0}};
            used_q      <= {(ADDR_WIDTH + 1){1'b0}};
            trk_q       <= {LAT{1'b0}};
            head_q      <= BP_ZERO;
            tail_q      <= BP_ZERO;
            buf_count_q <= {BC_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            used_q      <= used_d;
            trk_q       <= trk_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            buf_count_q <= buf_count_d;
        end
    end

    // Output buffer payload; a word lands when its tracker bit leaves the last stage
    always_ff @(posedge clk_i) begin
        if (land_s) begin
            buf_mem_q[tail_q] <= ram_rd_data_s;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Two FIFO instances (plain and registered RAM output) share one random/directed
// stimulus stream; each has its own expected-word queue checked by a negedge monitor.

module tb_ram_fifo_ctrl;
    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_ready;
    logic [1:0] wr_ready;
    logic [1:0] rd_valid;
    logic [1:0] full;
    logic [1:0] empty;
    logic [7:0] rd_data [2];
    logic [5:0] used [2];

    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic [1:0] seen;
    logic       stream_chk;
    int         checks;
    int         errors;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_fifo_ctrl #(
            .DATA_WIDTH        (8),
            .ADDR_WIDTH        (5),
            .REGISTERED_OUTPUT (g)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .wr_data_i    (wr_data),
            .wr_valid_i   (wr_valid),
            .wr_ready_o   (wr_ready[g]),
            .rd_data_o    (rd_data[g]),
            .rd_valid_o   (rd_valid[g]),
            .rd_ready_i   (rd_ready),
            .used_words_o (used[g]),
            .full_o       (full[g]),
            .empty_o      (empty[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[R=%0d]: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference: the FIFO holds exactly the accepted-but-not-popped words, in order
    task automatic mon_one(input int k);
        int         sz;
        logic [7:0] head;
        sz   = (k == 0) ? sb0.size() : sb1.size();
        head = 8'h00;
        if (sz > 0) head = (k == 0) ? sb0[0] : sb1[0];
        check("used", k, used[k], sz);
        check("full", k, full[k], sz == 32);
        check("empty", k, empty[k], sz == 0);
        check("wr_ready", k, wr_ready[k], sz < 32);
        if (rd_valid[k]) begin
            check("valid_nonempty", k, sz > 0, 1);
            check("rd_data", k, rd_data[k], head);
        end
        if (stream_chk && seen[k] && sz > 0) check("no_bubble", k, rd_valid[k], 1);
        if (!stream_chk) seen[k] = 1'b0;
        else if (rd_valid[k]) seen[k] = 1'b1;
        if (rd_valid[k] && rd_ready && sz > 0) begin
            if (k == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
        end
        if (wr_valid && wr_ready[k]) begin
            if (k == 0) sb0.push_back(wr_data);
            else        sb1.push_back(wr_data);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sb0.delete();
            sb1.delete();
        end else begin
            mon_one(0);
            mon_one(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n;
        n        = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        while (!(empty[0] && empty[1]) && n < 400) begin
            tick();
            n++;
        end
        check(nm, 0, empty[0] && empty[1], 1);
        rd_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        seen       = 2'b00;
        stream_chk = 1'b0;
        rst        = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'h11;
        rd_ready   = 1'b0;

        // 1: reset hold with a push request pending
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("rst_wr_ready", k, wr_ready[k], 0);
                check("rst_rd_valid", k, rd_valid[k], 0);
                check("rst_used", k, used[k], 0);
            end
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rel_wr_ready", k, wr_ready[k], 1);
            check("rel_rd_valid", k, rd_valid[k], 0);
            check("rel_empty", k, empty[k], 1);
            check("rel_full", k, full[k], 0);
        end

        // 2: single-word latency N+2+L
        tick();
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check("latency_valid", k, rd_valid[k], c >= 3 + k);
                if (c >= 3 + k) check("latency_data", k, rd_data[k], 8'hA5);
            end
            tick();
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("pop_used", k, used[k], 0);
            check("pop_empty", k, empty[k], 1);
        end
        tick();

        // 3: fill to capacity with the reader stalled
        for (int i = 0; i < 32; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        wr_data = 8'd32;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("fill_full", k, full[k], 1);
            check("fill_wr_ready", k, wr_ready[k], 0);
        end
        tick();

        // 5: pop at full does not open a slot in the same cycle
        rd_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("full_pop_used", k, used[k], 32);
            check("full_pop_wr_ready", k, wr_ready[k], 0);
        end
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("after_pop_used", k, used[k], 31);
            check("after_pop_wr_ready", k, wr_ready[k], 1);
        end
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check("refill_used", k, used[k], 32);
        tick();
        drain("drain_full");

        // 4: continuous streaming, no bubbles after the initial latency
        stream_chk = 1'b1;
        rd_ready   = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            tick();
        end
        drain("drain_stream");
        stream_chk = 1'b0;

        // 6: random valid/ready with a mid-stream reset
        for (int c = 0; c < 22000; c++) begin
            if (c == 9000) begin
                wr_valid = 1'b0;
                rd_ready = 1'b0;
                rst      = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    check("midrst_used", k, used[k], 0);
                    check("midrst_rd_valid", k, rd_valid[k], 0);
                    check("midrst_empty", k, empty[k], 1);
                    check("midrst_wr_ready", k, wr_ready[k], 1);
                end
            end
            wr_valid = ($urandom_range(0, 99) < (((c / 1500) % 2 == 0) ? 75 : 40));
            rd_ready = ($urandom_range(0, 99) < (((c / 1500) % 2 == 0) ? 40 : 75));
            wr_data  = 8'($urandom);
            tick();
        end
        drain("drain_random");
        check("sb_empty", 0, sb0.size() + sb1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
